norm_mult_ctrl: RTL and testbench
=================================

# norm_mult_ctrl

Parametrised sequencing controller for the normalise-multiply-denormalise datapath. It walks DEPTH operand pairs in memory. For each pair it loads both operands, left-normalises each until its MSB is 1, triggers the multiply, right-shifts the product back by the total normalisation count, and writes the result. Shift counters and address counters are internal. Memory writes use a ready handshake, so the block tolerates slow memories.

## Interface
- W, 8: operand width. CW = $clog2(W) is the shift-count width.
- DEPTH, 16: number of operand pairs. AW = (DEPTH>1) ? $clog2(DEPTH) : 1.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  run request; level, sampled in IDLE
- msb_a, msb_b  in  1  current MSB of datapath operand registers A/B
- zero_a, zero_b  in  1  operand register A/B is all-zero (used only with zero skip)
- mem_ready  in  1  memory accepts write this cycle
- rd_addr  out  AW+1  operand read address: 2*idx for A, 2*idx+1 for B
- wr_addr  out  AW  result write address (= idx)
- ld_a, ld_b  out  1  load operand register A/B from memory
- shl_a, shl_b  out  1  shift operand A/B left by 1
- ld_prod  out  1  capture product register
- shr_p  out  1  shift product right by 1
- clr_p  out  1  clear product register
- we  out  1  write request
- lsh_a, lsh_b  out  CW  left-shift counts of current pair
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after last write

## Operation
- States: IDLE, ARM, LOAD_A, LOAD_B, NORM, MUL, DENORM, WRITE, DONE.
- IDLE: start=1 -> ARM.
- ARM: idx<=0. Stay while start=1; start=0 -> LOAD_A.
- LOAD_A: ld_a=1, rd_addr={idx,0}, lsh_a<=0, lsh_b<=0 -> LOAD_B.
- LOAD_B: ld_b=1, rd_addr={idx,1} -> NORM.
- NORM: shl_a = ~msb_a & (lsh_a < W-1), and shl_a increments lsh_a. Same for B, independent and simultaneous. When neither shifts this cycle -> MUL.
- MUL: ld_prod=1, rcnt <= lsh_a + lsh_b (CW+1 bits, no overflow) -> DENORM.
- DENORM: if rcnt != 0, shr_p=1, rcnt decrements, stay. If rcnt == 0, no shift -> WRITE.
- WRITE: we=1 and wr_addr=idx, held until mem_ready. On we&mem_ready: if idx == DEPTH-1 -> DONE, else idx increments -> LOAD_A.
- DONE: done=1, idx<=0 -> IDLE.
- Outputs are decoded from state and counters. All strobes not listed for a state are 0.
- start is ignored outside IDLE/ARM.
- A zero operand without zero skip: its shifts saturate at W-1, then the flow proceeds normally.

## Timing
- Reset values: state IDLE, idx=0, lsh_a=lsh_b=0, rcnt=0, all strobes 0, busy=0, done=0, rd_addr=0, wr_addr=0.
- rst at any time, including mid-pair or during a stalled WRITE, returns to IDLE within the same cycle. Partial results are discarded and no write is issued.
- Per pair, with mem_ready=1: 2 + (max(lsh_a,lsh_b)+1) + 1 + (lsh_a+lsh_b+1) + 1 cycles.
- Each low cycle of mem_ready adds one WRITE cycle. Address and we stay stable during the stall.
- done is asserted the cycle after the final write handshake. busy falls the cycle after done.

## Configuration
- NORM_MULT_ZERO_SKIP_EN defined:
  - In the first NORM cycle, if zero_a|zero_b, then clr_p=1 and there are no shifts.
  - lsh_a and lsh_b stay 0, and the state goes directly to WRITE, skipping MUL and DENORM.
- Undefined:
  - zero_a and zero_b are ignored and clr_p is never asserted.
  - Zero operands take the saturation path.

## Test plan
- Reset: assert rst mid-run -> all outputs at reset values next edge; busy=0; no we.
- W=8, DEPTH=1, A normalises after 3 shifts, B after 1:
  - Required strobes: shl_a 3 cycles, shl_b 1 cycle, lsh_a=3, lsh_b=1, shr_p 4 cycles.
  - Required cycle timing: we at cycle 12 after LOAD_A, done at cycle 13.
- Already normalised operands (msb_a=msb_b=1): NORM 1 cycle, DENORM 1 cycle, no shl or shr, 6 cycles per pair.
- zero_a=1, W=8, B needs 2 shifts:
  - With macro: clr_p in cycle 2, we in cycle 3.
  - Without macro: shl_a 7 cycles, lsh_a=7, shr_p 9 cycles.
- mem_ready low for 3 cycles in WRITE -> we high for 4 cycles, wr_addr constant, a single idx increment.
- DEPTH=4 with start held high 5 cycles -> stays in ARM until start=0.
  - rd_addr sequence 0..7, wr_addr 0..3, one done pulse, then idx=0.

Source files
------------

// File: rtl/norm_mult_ctrl_if.sv
// Handshake/bus bundle between norm_mult_ctrl and its datapath/memory.
// master = controller side, slave = datapath/memory side.
interface norm_mult_ctrl_if #(
    parameter int W     = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(W);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          start;
    logic          msb_a;
    logic          msb_b;
    logic          zero_a;
    logic          zero_b;
    logic          mem_ready;
    logic [AW:0]   rd_addr;
    logic [AW-1:0] wr_addr;
    logic          ld_a;
    logic          ld_b;
    logic          shl_a;
    logic          shl_b;
    logic          ld_prod;
    logic          shr_p;
    logic          clr_p;
    logic          we;
    logic [CW-1:0] lsh_a;
    logic [CW-1:0] lsh_b;
    logic          busy;
    logic          done;

    modport master (
        input  start, msb_a, msb_b, zero_a, zero_b, mem_ready,
        output rd_addr, wr_addr, ld_a, ld_b, shl_a, shl_b,
        output ld_prod, shr_p, clr_p, we, lsh_a, lsh_b, busy, done
    );

    modport slave (
        output start, msb_a, msb_b, zero_a, zero_b, mem_ready,
        input  rd_addr, wr_addr, ld_a, ld_b, shl_a, shl_b,
        input  ld_prod, shr_p, clr_p, we, lsh_a, lsh_b, busy, done
    );
endinterface

// File: rtl/norm_mult_ctrl.sv
// Sequencer for the normalise-multiply-denormalise datapath.
// Define NORM_MULT_ZERO_SKIP_EN to bypass multiply for zero operands.
module norm_mult_ctrl #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input logic              clk,
    input logic              rst,
    norm_mult_ctrl_if.master bus
);
    localparam int CW = $clog2(W);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LSH_MAX  = CW'(W - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

    typedef enum logic [3:0] {
        IDLE, ARM, LOAD_A, LOAD_B, NORM, MUL, DENORM, WRITE, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] lsh_a_q, lsh_a_d;
    logic [CW-1:0] lsh_b_q, lsh_b_d;
    logic [CW:0]   rcnt_q, rcnt_d;
    logic          sa, sb, skip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lsh_a_q <= '0;
            lsh_b_q <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lsh_a_q <= lsh_a_d;
            lsh_b_q <= lsh_b_d;
            rcnt_q  <= rcnt_d;
        end
    end

`ifdef NORM_MULT_ZERO_SKIP_EN
    // Both counters are still zero only in the first NORM cycle.
    assign skip = (lsh_a_q == '0) && (lsh_b_q == '0)
                  && (bus.zero_a || bus.zero_b);
`else
    logic unused_zero;
    assign unused_zero = bus.zero_a | bus.zero_b;
    assign skip = 1'b0;
`endif

    assign bus.lsh_a   = lsh_a_q;
    assign bus.lsh_b   = lsh_b_q;
    assign bus.wr_addr = idx_q;
    assign bus.busy    = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lsh_a_d     = lsh_a_q;
        lsh_b_d     = lsh_b_q;
        rcnt_d      = rcnt_q;
        sa          = 1'b0;
        sb          = 1'b0;
        bus.rd_addr = {idx_q, 1'b0};
        bus.ld_a    = 1'b0;
        bus.ld_b    = 1'b0;
        bus.shl_a   = 1'b0;
        bus.shl_b   = 1'b0;
        bus.ld_prod = 1'b0;
        bus.shr_p   = 1'b0;
        bus.clr_p   = 1'b0;
        bus.we      = 1'b0;
        bus.done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = ARM;
            end
            ARM: begin
                idx_d = '0;
                if (!bus.start) state_d = LOAD_A;
            end
            LOAD_A: begin
                bus.ld_a = 1'b1;
                lsh_a_d  = '0;
                lsh_b_d  = '0;
                state_d  = LOAD_B;
            end
            LOAD_B: begin
                bus.ld_b    = 1'b1;
                bus.rd_addr = {idx_q, 1'b1};
                state_d     = NORM;
            end
            NORM: begin
                if (skip) begin
                    bus.clr_p = 1'b1;
                    state_d   = WRITE;
                end else begin
                    sa = ~bus.msb_a & (lsh_a_q < LSH_MAX);
                    sb = ~bus.msb_b & (lsh_b_q < LSH_MAX);
                    bus.shl_a = sa;
                    bus.shl_b = sb;
                    if (sa) lsh_a_d = lsh_a_q + CW'(1);
                    if (sb) lsh_b_d = lsh_b_q + CW'(1);
                    if (!sa && !sb) state_d = MUL;
                end
            end
            MUL: begin
                bus.ld_prod = 1'b1;
                rcnt_d  = {1'b0, lsh_a_q} + {1'b0, lsh_b_q};
                state_d = DENORM;
            end
            DENORM: begin
                if (rcnt_q != '0) begin
                    bus.shr_p = 1'b1;
                    rcnt_d    = rcnt_q - (CW+1)'(1);
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                bus.we = 1'b1;
                if (bus.mem_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = LOAD_A;
                    end
                end
            end
            DONE: begin
                bus.done = 1'b1;
                idx_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_norm_mult_ctrl.sv
// Directed bench for norm_mult_ctrl with a behavioural operand datapath.
// Zero-operand expectations follow NORM_MULT_ZERO_SKIP_EN.
module tb_norm_mult_ctrl;
    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_chk;

    norm_mult_ctrl_if #(.W(W), .DEPTH(DEPTH)) bus ();

    norm_mult_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] mem [0:2*DEPTH-1];
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    int           wr_q[$];

    assign bus.msb_a  = a_reg[W-1];
    assign bus.msb_b  = b_reg[W-1];
    assign bus.zero_a = (a_reg == '0);
    assign bus.zero_b = (b_reg == '0);

    always @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            if (bus.ld_a) a_reg <= mem[bus.rd_addr];
            else if (bus.shl_a) a_reg <= a_reg << 1;
            if (bus.ld_b) b_reg <= mem[bus.rd_addr];
            else if (bus.shl_b) b_reg <= b_reg << 1;
            if (bus.we && bus.mem_ready) wr_q.push_back(int'(bus.wr_addr));
        end
    end

    int n_shl_a, n_shl_b, n_shr, n_clr, n_we, n_done;
    int t_lda, t_we, t_done, t_clr;
    int lsh_a_mul, lsh_b_mul, lsh_a_we;
    int wr_bad;
    int rd_q[$];
    logic busy_after;
    bit fin;

    function automatic logic [9:0] strobes();
        return {bus.ld_a, bus.ld_b, bus.shl_a, bus.shl_b, bus.ld_prod,
                bus.shr_p, bus.clr_p, bus.we, bus.busy, bus.done};
    endfunction

    task automatic fill(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < DEPTH; i++) begin
            mem[2*i]   = a;
            mem[2*i+1] = b;
        end
    endtask

    task automatic run(input int hold, input int stall);
        int stl;
        int c;
        bit seen_done;
        bit prev_stall;
        int prev_wr;
        stl = stall;
        seen_done = 0;
        prev_stall = 0;
        prev_wr = 0;
        n_shl_a = 0; n_shl_b = 0; n_shr = 0; n_clr = 0;
        n_we = 0; n_done = 0; wr_bad = 0;
        t_lda = -1; t_we = -1; t_done = -1; t_clr = -1;
        lsh_a_mul = -1; lsh_b_mul = -1; lsh_a_we = -1;
        busy_after = 1'bx;
        fin = 0;
        rd_q.delete();
        wr_q.delete();
        c = 0;
        while (!fin && c < 1000) begin
            @(negedge clk);
            if (seen_done) begin
                busy_after = bus.busy;
                fin = 1;
            end else begin
                if (bus.ld_a && t_lda < 0) t_lda = c;
                if (bus.ld_a || bus.ld_b) rd_q.push_back(int'(bus.rd_addr));
                n_shl_a += int'(bus.shl_a);
                n_shl_b += int'(bus.shl_b);
                n_shr   += int'(bus.shr_p);
                n_clr   += int'(bus.clr_p);
                if (bus.clr_p && t_clr < 0) t_clr = c;
                if (bus.ld_prod) begin
                    lsh_a_mul = int'(bus.lsh_a);
                    lsh_b_mul = int'(bus.lsh_b);
                end
                if (bus.we) begin
                    n_we++;
                    if (t_we < 0) begin
                        t_we = c;
                        lsh_a_we = int'(bus.lsh_a);
                    end
                    if (prev_stall && int'(bus.wr_addr) != prev_wr) wr_bad++;
                end
                if (bus.we && stl > 0) begin
                    bus.mem_ready = 1'b0;
                    stl--;
                end else begin
                    bus.mem_ready = 1'b1;
                end
                prev_stall = bus.we && !bus.mem_ready;
                prev_wr = int'(bus.wr_addr);
                if (bus.done) begin
                    n_done++;
                    t_done = c;
                    seen_done = 1;
                end
                bus.start = (c < hold);
            end
            c++;
        end
        bus.start = 1'b0;
        bus.mem_ready = 1'b1;
        n_chk++;
        if (!fin) $display("FAIL run_timeout: got no done within %0d cycles", c);
        else n_pass++;
    endtask

    task automatic test_reset();
        bit seen;
        @(negedge clk);
        n_chk++;
        if (strobes() !== 10'b0)
            $display("FAIL rst_strobes: got %b want 0", strobes());
        else n_pass++;
        n_chk++;
        if (bus.rd_addr !== '0 || bus.wr_addr !== '0)
            $display("FAIL rst_addr: got rd=%0d wr=%0d want 0/0",
                     bus.rd_addr, bus.wr_addr);
        else n_pass++;
        n_chk++;
        if (bus.lsh_a !== '0 || bus.lsh_b !== '0)
            $display("FAIL rst_lsh: got %0d/%0d want 0/0", bus.lsh_a, bus.lsh_b);
        else n_pass++;
        rst = 1'b0;

        // reset while denormalising the first pair
        fill(8'h16, 8'h40);
        wr_q.delete();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        n_chk++;
        if (bus.shr_p !== 1'b1)
            $display("FAIL mid_denorm: got shr_p=%b want 1", bus.shr_p);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++;
        if (strobes() !== 10'b0 || bus.lsh_a !== '0)
            $display("FAIL mid_rst: got %b lsh_a=%0d want 0", strobes(), bus.lsh_a);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b0 || wr_q.size() != 0)
            $display("FAIL mid_rst_idle: got busy=%b writes=%0d want 0/0",
                     bus.busy, wr_q.size());
        else n_pass++;

        // reset during a stalled write of the second pair
        fill(8'h80, 8'hC3);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.we && bus.wr_addr == 1) begin
                seen = 1;
                bus.mem_ready = 1'b0;
            end
        end
        n_chk++;
        if (!seen) $display("FAIL stall_rst_reach: got no write to addr 1");
        else n_pass++;
        repeat (2) @(negedge clk);
        n_chk++;
        if (bus.we !== 1'b1 || bus.wr_addr !== 2'd1)
            $display("FAIL stall_hold: got we=%b wr=%0d want 1/1",
                     bus.we, bus.wr_addr);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++;
        if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.wr_addr !== '0)
            $display("FAIL stall_rst: got we=%b busy=%b wr=%0d want 0/0/0",
                     bus.we, bus.busy, bus.wr_addr);
        else n_pass++;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (wr_q.size() != 1)
            $display("FAIL stall_rst_writes: got %0d want 1", wr_q.size());
        else n_pass++;
    endtask

    task automatic test_norm_timing();
        fill(8'h16, 8'h40);
        run(1, 0);
        n_chk++;
        if (t_we - t_lda !== 12)
            $display("FAIL norm_we_cycle: got %0d want 12", t_we - t_lda);
        else n_pass++;
        n_chk++;
        if (t_done - t_lda !== 52)
            $display("FAIL norm_done_cycle: got %0d want 52", t_done - t_lda);
        else n_pass++;
        n_chk++;
        if (n_shl_a !== 12 || n_shl_b !== 4 || n_shr !== 16)
            $display("FAIL norm_shifts: got %0d/%0d/%0d want 12/4/16",
                     n_shl_a, n_shl_b, n_shr);
        else n_pass++;
        n_chk++;
        if (lsh_a_mul !== 3 || lsh_b_mul !== 1)
            $display("FAIL norm_lsh: got %0d/%0d want 3/1", lsh_a_mul, lsh_b_mul);
        else n_pass++;
        n_chk++;
        if (n_clr !== 0 || n_we !== 4)
            $display("FAIL norm_we_clr: got clr=%0d we=%0d want 0/4", n_clr, n_we);
        else n_pass++;
    endtask

    task automatic test_prenormalised();
        fill(8'h80, 8'hC3);
        run(1, 0);
        n_chk++;
        if (t_we - t_lda !== 5 || t_done - t_lda !== 24)
            $display("FAIL prenorm_timing: got we=%0d done=%0d want 5/24",
                     t_we - t_lda, t_done - t_lda);
        else n_pass++;
        n_chk++;
        if (n_shl_a + n_shl_b + n_shr !== 0)
            $display("FAIL prenorm_shifts: got %0d want 0", n_shl_a + n_shl_b + n_shr);
        else n_pass++;
    endtask

    task automatic test_zero_operand();
        fill(8'h00, 8'h20);
        run(1, 0);
`ifdef NORM_MULT_ZERO_SKIP_EN
        n_chk++;
        if (t_clr - t_lda !== 2 || t_we - t_lda !== 3)
            $display("FAIL zero_skip_timing: got clr=%0d we=%0d want 2/3",
                     t_clr - t_lda, t_we - t_lda);
        else n_pass++;
        n_chk++;
        if (n_clr !== 4 || n_shl_a + n_shl_b + n_shr !== 0 || lsh_a_we !== 0)
            $display("FAIL zero_skip_strobes: got clr=%0d shifts=%0d lsh_a=%0d want 4/0/0",
                     n_clr, n_shl_a + n_shl_b + n_shr, lsh_a_we);
        else n_pass++;
        n_chk++;
        if (t_done - t_lda !== 16)
            $display("FAIL zero_skip_done: got %0d want 16", t_done - t_lda);
        else n_pass++;
`else
        n_chk++;
        if (n_shl_a !== 28 || n_shl_b !== 8 || n_shr !== 36)
            $display("FAIL zero_sat_shifts: got %0d/%0d/%0d want 28/8/36",
                     n_shl_a, n_shl_b, n_shr);
        else n_pass++;
        n_chk++;
        if (lsh_a_mul !== 7 || lsh_b_mul !== 2 || n_clr !== 0)
            $display("FAIL zero_sat_lsh: got %0d/%0d clr=%0d want 7/2/0",
                     lsh_a_mul, lsh_b_mul, n_clr);
        else n_pass++;
        n_chk++;
        if (t_we - t_lda !== 21 || t_done - t_lda !== 88)
            $display("FAIL zero_sat_timing: got we=%0d done=%0d want 21/88",
                     t_we - t_lda, t_done - t_lda);
        else n_pass++;
`endif
    endtask

    task automatic test_write_stall();
        int bad;
        fill(8'h80, 8'h80);
        run(1, 3);
        bad = 0;
        if (wr_q.size() != 4) bad++;
        else for (int i = 0; i < 4; i++) if (wr_q[i] != i) bad++;
        n_chk++;
        if (n_we !== 7 || t_we - t_lda !== 5)
            $display("FAIL stall_we: got cycles=%0d first=%0d want 7/5",
                     n_we, t_we - t_lda);
        else n_pass++;
        n_chk++;
        if (bad !== 0 || wr_bad !== 0)
            $display("FAIL stall_addr: got writes=%0d bad=%0d unstable=%0d want 4/0/0",
                     wr_q.size(), bad, wr_bad);
        else n_pass++;
        n_chk++;
        if (t_done - t_lda !== 27)
            $display("FAIL stall_done: got %0d want 27", t_done - t_lda);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bad_rd;
        int bad_wr;
        fill(8'h80, 8'hFF);
        run(5, 0);
        bad_rd = 0;
        bad_wr = 0;
        if (rd_q.size() != 8) bad_rd++;
        else for (int i = 0; i < 8; i++) if (rd_q[i] != i) bad_rd++;
        if (wr_q.size() != 4) bad_wr++;
        else for (int i = 0; i < 4; i++) if (wr_q[i] != i) bad_wr++;
        n_chk++;
        if (t_lda !== 6)
            $display("FAIL arm_hold: got first ld_a at %0d want 6", t_lda);
        else n_pass++;
        n_chk++;
        if (bad_rd !== 0)
            $display("FAIL rd_seq: got %0d entries %0d bad want 8/0",
                     rd_q.size(), bad_rd);
        else n_pass++;
        n_chk++;
        if (bad_wr !== 0)
            $display("FAIL wr_seq: got %0d entries %0d bad want 4/0",
                     wr_q.size(), bad_wr);
        else n_pass++;
        n_chk++;
        if (n_done !== 1 || busy_after !== 1'b0)
            $display("FAIL done_pulse: got done=%0d busy_after=%b want 1/0",
                     n_done, busy_after);
        else n_pass++;
        n_chk++;
        if (bus.wr_addr !== '0 || bus.rd_addr !== '0)
            $display("FAIL idx_cleared: got wr=%0d rd=%0d want 0/0",
                     bus.wr_addr, bus.rd_addr);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_chk = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.mem_ready = 1'b1;
        fill(8'h00, 8'h00);
        test_reset();
        test_norm_timing();
        test_prenormalised();
        test_zero_operand();
        test_write_stall();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
